// File: rtl/ifu_npc.sv
// ifu_npc -- instruction fetch and next-PC unit for the multicycle MIPS core.
//
// Owns the PC and the instruction register (IR). It fetches the word at pc
// from instruction memory over a req/ack handshake, then presents the opcode
// field to the controller. It also applies the controller's PC-write enable
// and next-PC select, and drives pc+4 for the JAL link write.
//
// Parameters:
//   RESET_PC   PC value after reset
//   TIMEOUT    maximum cycles imem_req may stay high without an ack (1..255)
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   fetch_req           one-cycle pulse: fetch the instruction at pc
//   pc_we, npc_sel      PC write enable / next-PC select
//                       (00 pc+4, 01 branch, 10 jump, 11 register)
//   zero, rs_data       branch condition and register jump target
//   imem_ack/rdata      memory ack; the fetched word is valid with the ack
//   imem_req/addr       registered memory request; address equals pc
//   pc, pc_plus4        current PC and pc+4 (combinational)
//   ir, instr_op        instruction register and its opcode field
//   fetch_done          one-cycle pulse after ir is updated
//   fetch_err           sticky misaligned-fetch / timeout flag
//   busy                high while a fetch is outstanding
module ifu_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        pc_we,
    input  logic [1:0]  npc_sel,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic [5:0]  instr_op,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    // Counter value seen on the last permitted unacknowledged cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        req_q, req_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] npc;

    assign pc4    = pc_q + 32'd4;
    // Sign-extended word offset, already shifted into a byte offset.
    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_comb begin
        npc = pc4;
        case (npc_sel)
            2'b00: npc = pc4;
            2'b01: npc = zero ? (pc4 + br_off) : pc4;
            2'b10: npc = {pc4[31:28], ir_q[25:0], 2'b00};
            2'b11: npc = rs_data;   // alignment is checked on the next fetch
            default: npc = pc4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // A PC write wins over a simultaneous fetch; the fetch is dropped.
                if (pc_we) begin
                    pc_d = npc;
                end else if (fetch_req) begin
                    if (pc_q[1:0] == 2'b00) begin
                        req_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ERR: begin
                // Terminal until reset.
                req_d = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Asynchronous reset so an outstanding request is withdrawn immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc4;
    assign ir         = ir_q;
    assign instr_op   = ir_q[31:26];
    assign fetch_done = done_q;
    assign fetch_err  = err_q;
    assign busy       = (state_q == S_WAIT);

endmodule

// File: tb/tb_ifu_npc.sv
// Directed testbench for ifu_npc: fetch handshakes, next-PC selection,
// misaligned fetch, timeout, terminal error state and asynchronous reset.
module tb_ifu_npc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_we = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic [5:0]  instr_op;
    logic        fetch_done;
    logic        fetch_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    ifu_npc #(
        .RESET_PC(32'h0000_3000),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .pc_we     (pc_we),
        .npc_sel   (npc_sel),
        .zero      (zero),
        .rs_data   (rs_data),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .ir        (ir),
        .instr_op  (instr_op),
        .fetch_done(fetch_done),
        .fetch_err (fetch_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch with an ack in the first WAIT cycle.
    task automatic fetch0(input logic [31:0] word);
        fetch_req = 1'b1;
        step();
        fetch_req  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack = 1'b0;
        step();
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int req_cnt, busy_cnt, done_at, err_at;

    initial begin
        // ---- reset values ----
        step();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_ir", ir, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_done", {31'd0, fetch_done}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();

        // ---- zero-wait fetch ----
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("zw_req", {31'd0, imem_req}, 32'd1);
        check("zw_addr", imem_addr, 32'h0000_3000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3421_0005;
        step();
        imem_ack = 1'b0;
        check("zw_ir", ir, 32'h3421_0005);
        check("zw_op", {26'd0, instr_op}, 32'h0000_000D);
        check("zw_done", {31'd0, fetch_done}, 32'd1);
        check("zw_req_low", {31'd0, imem_req}, 32'd0);
        step();
        check("zw_done_pulse", {31'd0, fetch_done}, 32'd0);

        // ---- advance pc to 0x3004, then fetch with three wait cycles ----
        pc_we   = 1'b1;
        npc_sel = 2'b00;
        step();
        pc_we = 1'b0;
        check("inc_pc", pc, 32'h0000_3004);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        req_cnt = 0; busy_cnt = 0; done_at = -1;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) req_cnt++;
            if (busy) busy_cnt++;
            if (fetch_done && done_at < 0) done_at = i;
            imem_ack   = (i == 3);
            imem_rdata = 32'h1000_FFFF;
            step();
        end
        imem_ack = 1'b0;
        check("w3_req_cycles", req_cnt, 32'd4);
        check("w3_busy_cycles", busy_cnt, 32'd4);
        check("w3_done_at", done_at, 32'd4);
        check("w3_ir", ir, 32'h1000_FFFF);

        // ---- branch: offset -1 word ----
        pc_we = 1'b1; npc_sel = 2'b01; zero = 1'b1;
        step();
        check("br_taken", pc, 32'h0000_3004);
        zero = 1'b0;
        step();
        check("br_not_taken", pc, 32'h0000_3008);
        npc_sel = 2'b00;
        step();
        step();
        pc_we = 1'b0;
        check("pc_3010", pc, 32'h0000_3010);

        // ---- jump ----
        fetch0(32'h0C00_0C10);
        check("j_ir", ir, 32'h0C00_0C10);
        check("j_pc4_before", pc_plus4, 32'h0000_3014);
        pc_we = 1'b1; npc_sel = 2'b10;
        step();
        check("j_pc", pc, 32'h0000_3040);

        // ---- pc_we beats fetch_req; the fetch is dropped ----
        npc_sel = 2'b00; fetch_req = 1'b1;
        step();
        pc_we = 1'b0; fetch_req = 1'b0;
        check("prio_pc", pc, 32'h0000_3044);
        check("prio_no_req", {31'd0, imem_req}, 32'd0);
        step();
        check("prio_dropped", {31'd0, busy}, 32'd0);

        // ---- register jump to misaligned address, then fetch ----
        pc_we = 1'b1; npc_sel = 2'b11; rs_data = 32'h0000_3002;
        step();
        pc_we = 1'b0;
        check("jr_pc", pc, 32'h0000_3002);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("mis_err", {31'd0, fetch_err}, 32'd1);
        check("mis_no_req", {31'd0, imem_req}, 32'd0);
        step();
        check("mis_no_req2", {31'd0, imem_req}, 32'd0);

        // ---- timeout ----
        pulse_reset();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        req_cnt = 0; err_at = -1;
        for (int i = 0; i < 24; i++) begin
            if (imem_req) req_cnt++;
            if (fetch_err && err_at < 0) err_at = i;
            step();
        end
        check("to_req_cycles", req_cnt, 32'd16);
        check("to_err_at", err_at, 32'd16);
        // ERR ignores everything but reset
        fetch_req = 1'b1; pc_we = 1'b1; npc_sel = 2'b00;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) step();
        fetch_req = 1'b0; pc_we = 1'b0; imem_ack = 1'b0;
        check("err_pc", pc, 32'h0000_3000);
        check("err_ir", ir, 32'd0);
        check("err_req", {31'd0, imem_req}, 32'd0);
        check("err_sticky", {31'd0, fetch_err}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);

        // ---- reset during WAIT ----
        pulse_reset();
        check("rst_clears_err", {31'd0, fetch_err}, 32'd0);
        fetch0(32'h1234_5678);
        pc_we = 1'b1; npc_sel = 2'b00;
        step();
        pc_we = 1'b0;
        check("pre_pc", pc, 32'h0000_3004);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("pre_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_pc", pc, 32'h0000_3000);
        check("arst_ir", ir, 32'd0);
        step();
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        step();
        imem_ack = 1'b0;
        check("late_ack_ir", ir, 32'd0);
        check("late_ack_done", {31'd0, fetch_done}, 32'd0);
        check("late_ack_req", {31'd0, imem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_npc.md
# ifu_npc

Instruction fetch and next-PC unit for the multicycle MIPS core. It owns the PC and the instruction register, and fetches from instruction memory over a req/ack handshake. It feeds the opcode field to the multicycle controller and applies the controller's PC-write enable and next-PC select. It also drives PC+4 for the JAL link write.

## Interface
- RESET_PC, 32'h0000_3000: PC value after reset.
- TIMEOUT, 16: maximum number of cycles imem_req may stay high without an ack. Legal range 1..255.

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- fetch_req  in  1  one-cycle pulse from the controller: fetch the instruction at pc
- pc_we  in  1  PC write enable from the controller
- npc_sel  in  2  next-PC select: 00 pc+4, 01 branch, 10 jump, 11 register
- zero  in  1  ALU zero flag, used when npc_sel=01
- rs_data  in  32  register target, used when npc_sel=11
- imem_ack  in  1  memory ack; imem_rdata is valid in the same cycle
- imem_rdata  in  32  fetched word
- imem_req  out  1  memory request (registered)
- imem_addr  out  32  equals pc
- pc  out  32  current PC
- pc_plus4  out  32  pc+4, combinational, for the JAL link
- ir  out  32  instruction register
- instr_op  out  6  ir[31:26], routed to the controller
- fetch_done  out  1  one-cycle pulse: ir has been updated
- fetch_err  out  1  sticky: misaligned fetch or timeout
- busy  out  1  high while in WAIT

## Operation
- FSM states: IDLE, WAIT, ERR.
- Reset values: state=IDLE, pc=RESET_PC, ir=0, imem_req=0, fetch_done=0, fetch_err=0, timeout counter=0.

IDLE:
- If fetch_req=1, pc_we=0 and pc[1:0]=00: imem_req goes to 1, the counter clears, and the FSM moves to WAIT.
- If fetch_req=1 and pc[1:0]≠00: fetch_err goes to 1 and the FSM moves to ERR. No request is issued.
- If pc_we=1: pc loads npc. If fetch_req is also high in the same cycle, pc_we has priority and fetch_req is dropped (not queued).

WAIT:
- If imem_ack=1: ir loads imem_rdata, imem_req goes to 0, fetch_done=1 for the next cycle, and the FSM returns to IDLE.
- If imem_ack=0 and counter=TIMEOUT-1: imem_req goes to 0, fetch_err goes to 1, and the FSM moves to ERR.
- Otherwise the counter increments.
- fetch_req and pc_we are ignored in WAIT.

ERR:
- Only rst exits ERR.
- imem_req=0; pc_we and fetch_req are ignored.

imem_ack is ignored outside WAIT.

npc computation (all arithmetic is modulo 2^32, so 0xFFFF_FFFC+4 wraps to 0):
- 00: pc+4
- 01: if zero=1, pc+4+(sign-extended ir[15:0]<<2); otherwise pc+4
- 10: {pc_plus4[31:28], ir[25:0], 2'b00}
- 11: rs_data, loaded unchecked; a misaligned value is caught on the next fetch.

## Timing
- Fetch handshake, with fetch_req sampled at edge N:
  - imem_req is high from edge N through the edge where ack is sampled.
  - Zero-wait memory (ack in the first cycle): ir loads at edge N+1, and fetch_done is high from N+1 to N+2.
  - With k wait cycles, ir loads at edge N+1+k.
- Timeout: if no ack arrives, imem_req stays high for exactly TIMEOUT cycles. fetch_err rises at edge N+TIMEOUT.
- pc update: pc takes npc at the edge where pc_we=1 is sampled in IDLE.
  - The branch and jump paths use ir and pc as they stood before that edge.
- instr_op and pc_plus4 follow ir and pc combinationally.
- Reset mid-fetch: imem_req drops immediately (asynchronously), and every register takes its reset value. A late ack arriving after reset is ignored.

## Test plan
- Reset, then fetch_req with an ack in the same cycle and imem_rdata=0x3421_0005 -> imem_addr=0x3000, ir=0x3421_0005, instr_op=0x0D, one fetch_done pulse.
- Three wait cycles before ack -> imem_req high for 4 cycles, busy high for 4 cycles, fetch_done one cycle after the ack edge.
- ir=0x1000_FFFF, pc=0x3004, npc_sel=01, pc_we=1: with zero=1 -> pc=0x3004; with zero=0 -> pc=0x3008.
- ir=0x0C00_0C10, pc=0x3010, npc_sel=10 -> pc=0x0000_3040, pc_plus4=0x3014 before the edge. Then npc_sel=11 with rs_data=0x3002 and a fetch_req -> fetch_err=1, no imem_req.
- No ack with TIMEOUT=16 -> imem_req high for exactly 16 cycles, then fetch_err=1. Later fetch_req, pc_we and imem_ack have no effect until rst.
- rst asserted while in WAIT -> imem_req=0 immediately, pc=0x3000, ir=0. An ack in the next cycle does not load ir.
